fetch_db_rotbuf: RTL

- Parametrised successor to the fixed three-buffer deblock output store in the fetch stage.
- Manages NUM_BUF rotating LCU buffers of DEPTH words each, written by the deblock filter and drained by the external store engine.
- Adds occupancy tracking, full/empty handshake, overflow/underflow detection and synchronous flush, none of which the legacy store has.
- Sits between db and the ext_store path; the write-previous-LCU mode is retained.

---
 rtl/fetch_db_rotbuf.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_db_rotbuf.sv
//==============================================================================
// Module      : fetch_db_rotbuf
// Description : Rotating NUM_BUF x DEPTH deblock output store, with occupancy
//               tracking, full/empty handshake, overflow/underflow flags, flush.
// Revision    : 1.0  initial release
//==============================================================================
`default_nettype none

module fetch_db_rotbuf #(
   parameter int NUM_BUF = 3,
   parameter int DEPTH   = 256,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 256
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush_i,
   input  logic              wen_i,
   input  logic              wprevious_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              wdone_i,
   input  logic              ren_i,
   input  logic [ADDR_W-1:0] raddr_i,
   input  logic              rdone_i,
   output logic [DATA_W-1:0] rdata_o,
   output logic              rvalid_o,
   output logic              ready_o,
   output logic              full_o,
   output logic [3:0]        count_o,
   output logic [2:0]        wr_ptr_o,
   output logic [2:0]        rd_ptr_o,
   output logic              ovf_o,
   output logic              udf_o
);

   localparam int         MEM_AW = $clog2(NUM_BUF * DEPTH);
   localparam logic [2:0] c_LAST = 3'(NUM_BUF - 1);
   localparam logic [3:0] c_FULL = 4'(NUM_BUF);

   // All buffers share one flat array; buffer b occupies words [b*DEPTH, (b+1)*DEPTH)
   logic [DATA_W-1:0] r_mem [NUM_BUF*DEPTH];

   logic [2:0]        r_wr_ptr;
   logic [2:0]        r_rd_ptr;
   logic [3:0]        r_count;
   logic              r_ovf;
   logic              r_udf;
   logic              r_rvalid;
   logic [DATA_W-1:0] r_rdata;

   logic              w_full;
   logic              w_empty;
   logic [2:0]        w_wbuf;
   logic              w_wr_accept;
   logic [MEM_AW-1:0] w_widx;
   logic [MEM_AW-1:0] w_ridx;
   logic              w_com_ok;
   logic              w_rel_ok;
   logic              w_ovf_set;
   logic              w_udf_set;
   logic [3:0]        w_count_nxt;

   assign w_full  = (r_count == c_FULL);
   assign w_empty = (r_count == 4'd0);

   assign w_wbuf      = wprevious_i ? ((r_wr_ptr == 3'd0) ? c_LAST : r_wr_ptr - 3'd1)
                                    : r_wr_ptr;
   assign w_wr_accept = wen_i & (wprevious_i | ~w_full);
   assign w_widx      = MEM_AW'(w_wbuf) * MEM_AW'(DEPTH) + MEM_AW'(waddr_i);
   assign w_ridx      = MEM_AW'(r_rd_ptr) * MEM_AW'(DEPTH) + MEM_AW'(raddr_i);

   // Both handshakes are judged on the pre-edge count; a release frees a slot at full
   assign w_rel_ok  = rdone_i & ~w_empty;
   assign w_com_ok  = wdone_i & (~w_full | w_rel_ok);
   assign w_ovf_set = (wdone_i & ~w_com_ok) | (wen_i & ~wprevious_i & w_full);
   assign w_udf_set = rdone_i & ~w_rel_ok;

   always_comb begin
      w_count_nxt = r_count;
      case ({w_com_ok, w_rel_ok})
         2'b10:   w_count_nxt = r_count + 4'd1;
         2'b01:   w_count_nxt = r_count - 4'd1;
         default: w_count_nxt = r_count;
      endcase
   end

   // Writes land even during a flush, using the pre-flush pointer
   always_ff @(posedge clk) begin
      if (w_wr_accept)
         r_mem[w_widx] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr <= 3'd0;
         r_rd_ptr <= 3'd0;
         r_count  <= 4'd0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else if (flush_i) begin
         r_wr_ptr <= 3'd0;
         r_rd_ptr <= 3'd0;
         r_count  <= 4'd0;
         r_ovf    <= 1'b0;
         r_udf    <= 1'b0;
      end else begin
         if (w_com_ok)
            r_wr_ptr <= (r_wr_ptr == c_LAST) ? 3'd0 : r_wr_ptr + 3'd1;
         if (w_rel_ok)
            r_rd_ptr <= (r_rd_ptr == c_LAST) ? 3'd0 : r_rd_ptr + 3'd1;
         r_count <= w_count_nxt;
         if (w_ovf_set)
            r_ovf <= 1'b1;
         if (w_udf_set)
            r_udf <= 1'b1;
      end
   end

   // Read uses the pre-release rd_ptr and returns pre-write data on a collision
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
      end else if (flush_i) begin
         r_rvalid <= 1'b0;
      end else begin
         r_rvalid <= ren_i;
         if (ren_i)
            r_rdata <= r_mem[w_ridx];
      end
   end

   assign rdata_o  = r_rdata;
   assign rvalid_o = r_rvalid;
   assign ready_o  = ~w_empty;
   assign full_o   = w_full;
   assign count_o  = r_count;
   assign wr_ptr_o = r_wr_ptr;
   assign rd_ptr_o = r_rd_ptr;
   assign ovf_o    = r_ovf;
   assign udf_o    = r_udf;

endmodule

`default_nettype wire
